care_action_ctrl: RTL and testbench
===================================

# care_action_ctrl

Button-to-action front end for the pet core. Takes three raw push-buttons (next, prev, select), synchronises and debounces them, moves a menu cursor over the six care actions, and issues rate-limited single-cycle one-hot action pulses. Its `action` output drives the stats block's 8-bit `inputs` bus, where each pulse decrements the selected stat by one.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000: consecutive stable cycles required before a debounced level changes (10 ms at 27 MHz); legal range ≥ 2.
- `COOLDOWN_CYCLES`, default 13_500_000: dead time after each action pulse (0.5 s); legal range ≥ 1.
- `clk` in, 1: 27 MHz system clock.
- `reset` in, 1: one clock; reset is asynchronous and active-low.
- `btn_next` in, 1: raw, asynchronous, active-high; advances the cursor.
- `btn_prev` in, 1: raw, asynchronous, active-high; moves the cursor back.
- `btn_select` in, 1: raw, asynchronous, active-high; fires the action under the cursor.
- `action` out, 8: one-hot action pulse; bit `k` means action `k`. Bits 7:6 are always 0.
- `cursor` out, 3: current menu index, 0..5 (hunger, happiness, health, hygiene, energy, social).
- `busy` out, 1: high in FIRE and COOLDOWN.

## Operation
- **Input path:** each button goes through a 2-FF synchroniser, then the debouncer, then a registered rising-edge detector. The detector yields a 1-cycle `*_press` pulse.
- **Debounce:** the per-button counter clears whenever the synchronised input equals the debounced level. Otherwise it increments. The debounced level flips on the cycle the counter reaches `DEBOUNCE_CYCLES-1` while the inputs still differ, and the counter clears. Glitches shorter than `DEBOUNCE_CYCLES` are never seen.
- **Cursor** (runs in every FSM state):
  - `next_press` alone: increment, with 5→0 wrap.
  - `prev_press` alone: decrement, with 0→5 wrap.
  - Both in the same cycle: no change.
- **FSM states:** IDLE, FIRE, COOLDOWN.
  - IDLE → FIRE on `sel_press`. The cursor value in that cycle (before any same-cycle move) is latched as the action index.
  - FIRE lasts exactly 1 cycle. `action = 1 << idx` during FIRE, and 0 in all other states.
  - FIRE → COOLDOWN. The cooldown counter loads 0 and COOLDOWN lasts exactly `COOLDOWN_CYCLES` cycles.
  - COOLDOWN → IDLE at expiry (see Configuration for auto-repeat).
- **During FIRE and COOLDOWN:** `sel_press` is discarded, not queued. Cursor moves are still accepted.
- **Widths:**
  - Debounce counters: `$clog2(DEBOUNCE_CYCLES)` bits.
  - Cooldown counter: `$clog2(COOLDOWN_CYCLES+1)` bits.
  - Neither counter ever wraps.

## Timing
- **Reset values** (while `reset`=0):
  - Outputs: `action`=8'h00, `cursor`=0, `busy`=0.
  - Internal: FSM in IDLE, synchroniser flops, debounced levels, edge registers and all counters at 0.
- **Reset mid-operation:** takes effect asynchronously. An in-flight FIRE pulse is truncated and the cooldown is abandoned. After release, a button already held high needs a full debounce interval plus a rising edge before it acts.
- **Latency:** from the first `clk` edge that samples a stable-high raw button, `*_press` is asserted `DEBOUNCE_CYCLES+3` edges later. `action` is asserted 1 edge after `sel_press`, and `cursor` updates 1 edge after `next_press`/`prev_press`.
- **Pulse spacing:** minimum spacing between consecutive `action` pulses is `COOLDOWN_CYCLES+1` cycles.
- **Output registers:** `busy` rises in the same cycle as `action`, and falls on the cycle the FSM re-enters IDLE. All outputs are registered.

## Configuration
- **`CARE_AUTOREPEAT_EN` defined:** at COOLDOWN expiry, if the debounced select level is still high, go directly to FIRE. The action index is re-latched from the current cursor, so a held select fires once every `COOLDOWN_CYCLES+1` cycles.
- **`CARE_AUTOREPEAT_EN` undefined:** COOLDOWN always returns to IDLE. A new select rising edge is required for every action.

## Structure
- **Package `care_pkg`:**
  - `NUM_ACTIONS` = 6 and `ACTION_W` = 8.
  - Action index constants `ACT_HUNGER`..`ACT_SOCIAL` (0..5), so these indices stay consistent with the stats block.
  - FSM state enum `care_state_t` (IDLE, FIRE, COOLDOWN).
- **Sub-module `button_debounce`:** parameterised by `DEBOUNCE_CYCLES`; contains the synchroniser, debounce counter and edge detector; outputs `level` and `press`. It is instantiated three times.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `COOLDOWN_CYCLES`=8.
- **Reset defaults:** reset low for 3 cycles with all buttons high → `action`=0, `cursor`=0, `busy`=0. After release with buttons still high, no action until select is released and pressed again.
- **Debounce rejection:** 3-cycle select glitch → no `action` pulse. A clean 20-cycle press → exactly one `action`=8'h01, 1 cycle wide, 8 edges after the first sampled high edge.
- **Cursor wrap:**
  - Five next presses → `cursor`=5; a sixth → 0.
  - One prev press from 0 → 5.
  - Simultaneous next and prev → unchanged.
- **Fire from cursor 3 with cooldown:** `cursor`=3, select → `action`=8'h08 and `busy`=1 for 9 cycles. A second select press inside the cooldown produces no pulse; a select after `busy` falls gives a new 8'h08 pulse.
- **Same-cycle select and next:** cursor 2, presses aligned → `action`=8'h04 and `cursor` becomes 3.
- **Held select for 40 cycles:**
  - With `CARE_AUTOREPEAT_EN`: pulses spaced exactly 9 cycles apart.
  - Without it: exactly one pulse.
  - Reset asserted during COOLDOWN → `busy`=0 immediately.

Source files
------------

// File: rtl/care_pkg.sv
// Shared constants, FSM state type and small helpers for the care-action front end.
// The action indices match the bit order of the stats block's inputs bus.
package care_pkg;

  localparam int NUM_ACTIONS = 6;
  localparam int ACTION_W    = 8;

  localparam logic [2:0] ACT_HUNGER    = 3'd0;
  localparam logic [2:0] ACT_HAPPINESS = 3'd1;
  localparam logic [2:0] ACT_HEALTH    = 3'd2;
  localparam logic [2:0] ACT_HYGIENE   = 3'd3;
  localparam logic [2:0] ACT_ENERGY    = 3'd4;
  localparam logic [2:0] ACT_SOCIAL    = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } care_state_t;

  function automatic logic [ACTION_W-1:0] action_onehot(input logic [2:0] idx);
    logic [ACTION_W-1:0] v;
    case (idx)
      ACT_HUNGER:    v = 8'h01;
      ACT_HAPPINESS: v = 8'h02;
      ACT_HEALTH:    v = 8'h04;
      ACT_HYGIENE:   v = 8'h08;
      ACT_ENERGY:    v = 8'h10;
      ACT_SOCIAL:    v = 8'h20;
      default:       v = 8'h00;
    endcase
    return v;
  endfunction

  // Simultaneous next and prev cancel each other out.
  function automatic logic [2:0] cursor_step(input logic [2:0] cur,
                                             input logic       step_next,
                                             input logic       step_prev);
    logic [2:0] v;
    case ({step_next, step_prev})
      2'b10:   v = (cur >= ACT_SOCIAL) ? ACT_HUNGER : cur + 3'd1;
      2'b01:   v = (cur == ACT_HUNGER) ? ACT_SOCIAL : cur - 3'd1;
      default: v = cur;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/care_action_ctrl_button_debounce.sv
// One push-button channel: 2-FF synchroniser, counting debouncer and registered
// rising-edge detector producing a single-cycle press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          armed_r;
  logic          level_r;
  logic          edge_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // A button held through reset must first be seen released for a full
  // interval (armed_r) before the debounced level may rise again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (!armed_r) begin
      if (sync2_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= '0;
        armed_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else if (sync2_r == level_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= sync2_r;
      cnt_r   <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Registered rising-edge detector on the debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      edge_r  <= level_r;
      press_r <= level_r & ~edge_r;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/care_action_ctrl.sv
// Button-to-action front end: debounced menu cursor plus rate-limited one-hot action pulses.
// Optional build macro CARE_AUTOREPEAT_EN: a held select re-fires at every cooldown expiry.
module care_action_ctrl
  import care_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int COOLDOWN_CYCLES = 13_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_select,
  output logic [ACTION_W-1:0] action,
  output logic [2:0]          cursor,
  output logic                busy
);

  localparam int CDW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'(IDLE);
  localparam logic [1:0] S_FIRE     = 2'(FIRE);
  localparam logic [1:0] S_COOLDOWN = 2'(COOLDOWN);

  logic next_level;
  logic prev_level;
  logic sel_level;
  logic next_press;
  logic prev_press;
  logic sel_press;
  logic unused_levels;

  logic [1:0]          state_r;
  logic [1:0]          state_nx;
  logic [2:0]          idx_r;
  logic [2:0]          idx_nx;
  logic [CDW-1:0]      cd_r;
  logic [CDW-1:0]      cd_nx;
  logic [2:0]          cursor_r;
  logic [2:0]          cursor_nx;
  logic [ACTION_W-1:0] action_r;
  logic                busy_r;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_next),
    .level (next_level),
    .press (next_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_prev),
    .level (prev_level),
    .press (prev_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_select),
    .level (sel_level),
    .press (sel_press)
  );

  assign unused_levels = &{1'b0, next_level, prev_level, sel_level};

  // Cursor movement is accepted in every FSM state.
  always_comb begin
    cursor_nx = cursor_step(cursor_r, next_press, prev_press);
  end

  // Action FSM; the fired index is the cursor before any same-cycle move.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    cd_nx    = cd_r;
    case (state_r)
      S_IDLE: begin
        if (sel_press) begin
          state_nx = S_FIRE;
          idx_nx   = cursor_r;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FIRE: begin
        state_nx = S_COOLDOWN;
        cd_nx    = '0;
      end
      S_COOLDOWN: begin
        if (cd_r == CD_LAST) begin
          cd_nx = '0;
`ifdef CARE_AUTOREPEAT_EN
          if (sel_level) begin
            state_nx = S_FIRE;
            idx_nx   = cursor_r;
          end else begin
            state_nx = S_IDLE;
          end
`else
          state_nx = S_IDLE;
`endif
        end else begin
          cd_nx = cd_r + CDW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cd_nx    = '0;
      end
    endcase
  end

  // State, counters and the registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      idx_r    <= ACT_HUNGER;
      cd_r     <= '0;
      cursor_r <= ACT_HUNGER;
      action_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      idx_r    <= idx_nx;
      cd_r     <= cd_nx;
      cursor_r <= cursor_nx;
      action_r <= (state_nx == S_FIRE) ? action_onehot(idx_nx) : '0;
      busy_r   <= (state_nx != S_IDLE);
    end
  end

  assign action = action_r;
  assign cursor = cursor_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_care_action_ctrl.sv
// Self-checking bench for care_action_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
// Every nonzero action cycle is logged; tasks compare the log against a cursor/pulse model.
module tb_care_action_ctrl;

  localparam int DEB = 4;
  localparam int CD  = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_select = 1'b0;
  logic [7:0] action;
  logic [2:0] cursor;
  logic       busy;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int busy_cyc = 0;
  int cursor_m = 0;
  logic [7:0] act_q[$];
  int         stamp_q[$];

  care_action_ctrl #(.DEBOUNCE_CYCLES(DEB), .COOLDOWN_CYCLES(CD)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_select (btn_select),
    .action     (action),
    .cursor     (cursor),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (action !== 8'h00) begin
      act_q.push_back(action);
      stamp_q.push_back(cyc);
    end
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
  end

  function automatic logic [7:0] onehot(input int idx);
    logic [7:0] v;
    v = 8'h00;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pulses from one clean select held for 'hold' sampled cycles: a held level
  // re-fires every CD+1 cycles while still high at each expiry decision.
  function automatic int exp_pulses(input int hold);
`ifdef CARE_AUTOREPEAT_EN
    return (hold - 2) / (CD + 1) + 1;
`else
    return 1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // s = first posedge that samples the raised buttons.
  task automatic press(input logic nx, input logic pv, input logic sl,
                       input int hold, input int gap, output int s);
    @(negedge clk);
    s = cyc + 1;
    btn_next = nx; btn_prev = pv; btn_select = sl;
    tick(hold);
    btn_next = 1'b0; btn_prev = 1'b0; btn_select = 1'b0;
    tick(gap);
  endtask

  task automatic move_to(input int target);
    int s;
    while (cursor_m != target) begin
      press(1'b1, 1'b0, 1'b0, 6, 8, s);
      cursor_m = (cursor_m + 1) % 6;
    end
  endtask

  task automatic test_reset();
    int base, s;
    btn_next = 1'b1; btn_prev = 1'b1; btn_select = 1'b1;
    reset_n = 1'b0;
    tick(3);
    nvec++; if (action !== 8'h00) begin nerr++; $display("FAIL reset_action: got %h want 00", action); end
    nvec++; if (cursor !== 3'd0) begin nerr++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    base = act_q.size();
    tick(30);
    nvec++; if (act_q.size() != base) begin nerr++; $display("FAIL held_after_reset: got %0d pulses want 0", act_q.size() - base); end
    nvec++; if (cursor !== 3'd0) begin nerr++; $display("FAIL held_after_reset_cursor: got %0d want 0", cursor); end
    btn_next = 1'b0; btn_prev = 1'b0; btn_select = 1'b0;
    tick(20);
    nvec++; if (act_q.size() != base) begin nerr++; $display("FAIL release_after_reset: got %0d pulses want 0", act_q.size() - base); end
    press(1'b0, 1'b0, 1'b1, 6, 20, s);
    nvec++; if (act_q.size() != base + 1) begin nerr++; $display("FAIL repress_count: got %0d want 1", act_q.size() - base); end
    else begin
      nvec++; if (act_q[base] !== onehot(cursor_m)) begin nerr++; $display("FAIL repress_value: got %h want %h", act_q[base], onehot(cursor_m)); end
    end
  endtask

  task automatic test_debounce();
    int base, s, n;
    base = act_q.size();
    press(1'b0, 1'b0, 1'b1, DEB - 1, 20, s);
    nvec++; if (act_q.size() != base) begin nerr++; $display("FAIL glitch: got %0d pulses want 0", act_q.size() - base); end
    base = act_q.size();
    n = exp_pulses(20);
    press(1'b0, 1'b0, 1'b1, 20, 30, s);
    nvec++; if (act_q.size() != base + n) begin nerr++; $display("FAIL clean_count: got %0d want %0d", act_q.size() - base, n); end
    else begin
      nvec++; if (act_q[base] !== 8'h01) begin nerr++; $display("FAIL clean_value: got %h want 01", act_q[base]); end
      // Sampling edge counts as edge 1: 2 sync + DEB debounce + edge detect + action register.
      nvec++; if (stamp_q[base] != s + DEB + 3) begin nerr++; $display("FAIL clean_latency: got cycle %0d want %0d", stamp_q[base], s + DEB + 3); end
    end
  endtask

  task automatic test_cursor_wrap();
    int s, base;
    base = act_q.size();
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0, 1'b0, 6, 8, s);
      cursor_m = (cursor_m + 1) % 6;
      nvec++; if (cursor !== 3'(cursor_m)) begin nerr++; $display("FAIL next_%0d: got %0d want %0d", i, cursor, cursor_m); end
    end
    press(1'b0, 1'b1, 1'b0, 6, 8, s);
    cursor_m = (cursor_m + 5) % 6;
    nvec++; if (cursor !== 3'(cursor_m)) begin nerr++; $display("FAIL prev_wrap: got %0d want %0d", cursor, cursor_m); end
    press(1'b1, 1'b1, 1'b0, 6, 8, s);
    nvec++; if (cursor !== 3'(cursor_m)) begin nerr++; $display("FAIL both_hold: got %0d want %0d", cursor, cursor_m); end
    nvec++; if (act_q.size() != base) begin nerr++; $display("FAIL cursor_no_action: got %0d pulses want 0", act_q.size() - base); end
  endtask

  task automatic test_fire_cooldown();
    int base, b0, s, s2, npl, nbusy;
    move_to(3);
    base = act_q.size();
    b0 = busy_cyc;
    // Exactly-DEB press, DEB release, then a second press landing inside the cooldown.
    @(negedge clk);
    s = cyc + 1;
    btn_select = 1'b1; tick(DEB);
    btn_select = 1'b0; tick(DEB);
    btn_select = 1'b1; tick(6);
    btn_select = 1'b0; tick(25);
`ifdef CARE_AUTOREPEAT_EN
    npl = 2; nbusy = 2 * (CD + 1);
`else
    npl = 1; nbusy = CD + 1;
`endif
    nvec++; if (act_q.size() != base + npl) begin nerr++; $display("FAIL cooldown_count: got %0d want %0d", act_q.size() - base, npl); end
    else begin
      nvec++; if (act_q[base] !== 8'h08) begin nerr++; $display("FAIL fire3_value: got %h want 08", act_q[base]); end
      nvec++; if (stamp_q[base] != s + DEB + 3) begin nerr++; $display("FAIL fire3_time: got %0d want %0d", stamp_q[base], s + DEB + 3); end
    end
    nvec++; if (busy_cyc - b0 != nbusy) begin nerr++; $display("FAIL busy_width: got %0d want %0d", busy_cyc - b0, nbusy); end
    base = act_q.size();
    b0 = busy_cyc;
    press(1'b0, 1'b0, 1'b1, 6, 20, s2);
    nvec++; if (act_q.size() != base + 1) begin nerr++; $display("FAIL after_busy_count: got %0d want 1", act_q.size() - base); end
    else begin
      nvec++; if (act_q[base] !== 8'h08) begin nerr++; $display("FAIL after_busy_value: got %h want 08", act_q[base]); end
    end
    nvec++; if (busy_cyc - b0 != CD + 1) begin nerr++; $display("FAIL busy_width2: got %0d want %0d", busy_cyc - b0, CD + 1); end
  endtask

  task automatic test_same_cycle();
    int base, s;
    move_to(2);
    base = act_q.size();
    press(1'b1, 1'b0, 1'b1, 6, 20, s);
    nvec++; if (act_q.size() != base + 1) begin nerr++; $display("FAIL sel_next_count: got %0d want 1", act_q.size() - base); end
    else begin
      nvec++; if (act_q[base] !== 8'h04) begin nerr++; $display("FAIL sel_next_value: got %h want 04", act_q[base]); end
    end
    cursor_m = 3;
    nvec++; if (cursor !== 3'd3) begin nerr++; $display("FAIL sel_next_cursor: got %0d want 3", cursor); end
  endtask

  task automatic test_random();
    int base, s, op, hold, gap, n;
    logic nx, pv, sl;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 4);
      nx = (op == 0) || (op == 2) || (op == 4);
      pv = (op == 1) || (op == 2);
      sl = (op == 3) || (op == 4);
      hold = $urandom_range(5, 9);
      gap = $urandom_range(12, 18);
      base = act_q.size();
      press(nx, pv, sl, hold, gap, s);
      n = sl ? exp_pulses(hold) : 0;
      nvec++; if (act_q.size() != base + n) begin nerr++; $display("FAIL rand%0d_count: got %0d want %0d", i, act_q.size() - base, n); end
      else if (n > 0) begin
        nvec++; if (act_q[base] !== onehot(cursor_m)) begin nerr++; $display("FAIL rand%0d_value: got %h want %h", i, act_q[base], onehot(cursor_m)); end
      end
      if (nx && !pv) cursor_m = (cursor_m + 1) % 6;
      if (pv && !nx) cursor_m = (cursor_m + 5) % 6;
      nvec++; if (cursor !== 3'(cursor_m)) begin nerr++; $display("FAIL rand%0d_cursor: got %0d want %0d", i, cursor, cursor_m); end
    end
  endtask

  task automatic test_held_select();
    int base, s, n;
    base = act_q.size();
    n = exp_pulses(40);
    press(1'b0, 1'b0, 1'b1, 40, 30, s);
    nvec++; if (act_q.size() != base + n) begin nerr++; $display("FAIL held_count: got %0d want %0d", act_q.size() - base, n); end
    else begin
      for (int k = 0; k < n; k++) begin
        nvec++; if (act_q[base + k] !== onehot(cursor_m)) begin nerr++; $display("FAIL held_value%0d: got %h want %h", k, act_q[base + k], onehot(cursor_m)); end
        nvec++; if (stamp_q[base + k] != s + DEB + 3 + k * (CD + 1)) begin nerr++; $display("FAIL held_time%0d: got %0d want %0d", k, stamp_q[base + k], s + DEB + 3 + k * (CD + 1)); end
      end
    end
  endtask

  task automatic test_reset_in_cooldown();
    int base, s;
    press(1'b0, 1'b0, 1'b1, 6, 0, s);
    tick(5);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL cooldown_busy: got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    nvec++; if (cursor !== 3'd0) begin nerr++; $display("FAIL async_reset_cursor: got %0d want 0", cursor); end
    tick(2);
    reset_n = 1'b1;
    cursor_m = 0;
    tick(20);
    base = act_q.size();
    press(1'b0, 1'b0, 1'b1, 6, 20, s);
    nvec++; if (act_q.size() != base + 1) begin nerr++; $display("FAIL recover_count: got %0d want 1", act_q.size() - base); end
    else begin
      nvec++; if (act_q[base] !== 8'h01) begin nerr++; $display("FAIL recover_value: got %h want 01", act_q[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_cursor_wrap();
    test_fire_cooldown();
    test_same_cycle();
    test_random();
    test_held_select();
    test_reset_in_cooldown();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
